// File: rtl/noc_mbox_pkg.sv
// noc_mbox_pkg: shared defaults, the FIFO entry layout and a saturating counter
// helper for the NoC mailbox.
package noc_mbox_pkg;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_DEPTH        = 4;
  localparam int DEF_DROP_ON_FULL = 0;

  localparam logic [7:0] OVF_MAX  = 8'hFF;

  // Entry layout at default widths; the top re-declares the same layout
  // with its own ADDR_W/DATA_W so non-default builds keep {addr, data}.
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } mbox_entry_t;

  localparam int ENTRY_W = $bits(mbox_entry_t);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == OVF_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/noc_mailbox_if.sv
// noc_mailbox_if: CPU-side and network-side signals of the mailbox.
//   slave  : mailbox view (drives status, rx head, tx head, rx ready)
//   master : CPU/network view (drives strobes, tx payload, rx packets, tx ready)
interface noc_mailbox_if
  import noc_mbox_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // CPU send side
  logic [ADDR_W-1:0] send_addr;
  logic [DATA_W-1:0] send_data;
  logic              send_wr;
  logic              send_full;
  logic              ack;
  // CPU receive side
  logic [ADDR_W-1:0] recv_addr;
  logic [DATA_W-1:0] recv_data;
  logic              recv_valid;
  logic              recv_rd;
  logic [CNT_W-1:0]  rx_count;
  logic [7:0]        overflow_cnt;
  // network tx
  logic [ADDR_W-1:0] net_tx_addr;
  logic [DATA_W-1:0] net_tx_data;
  logic              net_tx_valid;
  logic              net_tx_ready;
  // network rx
  logic [ADDR_W-1:0] net_rx_addr;
  logic [DATA_W-1:0] net_rx_data;
  logic              net_rx_valid;
  logic              net_rx_ready;

  modport slave (
    input  send_addr, send_data, send_wr, recv_rd, net_tx_ready,
           net_rx_addr, net_rx_data, net_rx_valid,
    output send_full, ack, recv_addr, recv_data, recv_valid, rx_count,
           overflow_cnt, net_tx_addr, net_tx_data, net_tx_valid, net_rx_ready
  );

  modport master (
    output send_addr, send_data, send_wr, recv_rd, net_tx_ready,
           net_rx_addr, net_rx_data, net_rx_valid,
    input  send_full, ack, recv_addr, recv_data, recv_valid, rx_count,
           overflow_cnt, net_tx_addr, net_tx_data, net_tx_valid, net_rx_ready
  );

endinterface

// File: rtl/noc_mbox_fifo.sv
// noc_mbox_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst        : clock, async active-high reset
//   wr_en, wr_data  : push request (ignored while full)
//   rd_en           : pop request (ignored while empty)
//   rd_data         : head entry, zero while empty
//   count/full/empty: occupancy and flags
// DEPTH must be a power of two (2..64) so the pointers wrap for free.
module noc_mbox_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  // Flags come from the registered count, so a same-edge pop never makes
  // room for a push on a full FIFO.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_mailbox.sv
// noc_mailbox: CPU <-> NoC mailbox with a tx FIFO (CPU -> network) and an
// rx FIFO (network -> CPU), both first-word-fall-through.
//   clocks_ref_clk_clk     : clock
//   clocks_ref_reset_reset : async active-high reset
//   mbox                   : CPU and network handshakes (slave modport)
// DROP_ON_FULL=0 backpressures the network when rx is full; 1 keeps
// net_rx_ready high and counts discarded packets in overflow_cnt.
module noc_mailbox
  import noc_mbox_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int DROP_ON_FULL = DEF_DROP_ON_FULL
) (
  input  logic         clocks_ref_clk_clk,
  input  logic         clocks_ref_reset_reset,
  noc_mailbox_if.slave mbox
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam int EW = $bits(entry_t);

  logic clk, rst;
  assign clk = clocks_ref_clk_clk;
  assign rst = clocks_ref_reset_reset;

  // ---------------- tx path ----------------
  entry_t           tx_in, tx_head;
  logic             tx_full, tx_empty;
  logic [CNT_W-1:0] tx_count;

  assign tx_in.addr = mbox.send_addr;
  assign tx_in.data = mbox.send_data;

  noc_mbox_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mbox.send_wr),
    .wr_data (tx_in),
    .rd_en   (mbox.net_tx_ready),
    .rd_data (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  logic unused_tx_count;
  assign unused_tx_count = ^tx_count;

  assign mbox.send_full    = tx_full;
  assign mbox.net_tx_valid = ~tx_empty;
  assign mbox.net_tx_addr  = tx_head.addr;
  assign mbox.net_tx_data  = tx_head.data;

  // ack mirrors the FIFO's own push condition, one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mbox.ack <= 1'b0;
    else     mbox.ack <= mbox.send_wr & ~tx_full;
  end

  // ---------------- rx path ----------------
  entry_t           rx_in, rx_head;
  logic             rx_full, rx_empty;
  logic             rx_ready, rx_drop;
  logic [7:0]       ovf_q;

  assign rx_in.addr = mbox.net_rx_addr;
  assign rx_in.data = mbox.net_rx_data;

  // Ready is forced low while reset is held and rises as soon as it drops.
  assign rx_ready = ~rst & ((DROP_ON_FULL != 0) ? 1'b1 : ~rx_full);

  // In drop mode a full FIFO still handshakes; the FIFO refuses the push.
  assign rx_drop  = (DROP_ON_FULL != 0) & mbox.net_rx_valid & rx_full;

  noc_mbox_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mbox.net_rx_valid & rx_ready),
    .wr_data (rx_in),
    .rd_en   (mbox.recv_rd),
    .rd_data (rx_head),
    .count   (mbox.rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf_q <= '0;
    else if (rx_drop) ovf_q <= sat_inc8(ovf_q);
  end

  assign mbox.net_rx_ready = rx_ready;
  assign mbox.recv_valid   = ~rx_empty;
  assign mbox.recv_addr    = rx_head.addr;
  assign mbox.recv_data    = rx_head.data;
  assign mbox.overflow_cnt = ovf_q;

endmodule

// File: tb/tb_noc_mailbox.sv
module tb_noc_mailbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_mailbox_if #(.DATA_W(32), .ADDR_W(8), .DEPTH(4)) if0 ();
  noc_mailbox_if #(.DATA_W(32), .ADDR_W(8), .DEPTH(4)) if1 ();

  noc_mailbox #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .DROP_ON_FULL(0)) dut0 (
    .clocks_ref_clk_clk     (clk),
    .clocks_ref_reset_reset (rst),
    .mbox                   (if0)
  );

  noc_mailbox #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .DROP_ON_FULL(1)) dut1 (
    .clocks_ref_clk_clk     (clk),
    .clocks_ref_reset_reset (rst),
    .mbox                   (if1)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  a;
    logic [31:0] d;
    logic        txr;
    logic        e_ack;
    logic        e_full;
    logic        e_txv;
    logic [7:0]  e_txa;
    logic [31:0] e_txd;
  } tx_vec_t;

  typedef struct {
    logic        rxv;
    logic [7:0]  ra;
    logic [31:0] rd;
    logic        rrd;
    logic        e_rv;
    logic [7:0]  e_ra;
    logic [31:0] e_rd;
    logic [2:0]  e_cnt;
    logic        e_rdy;
  } rx_vec_t;

  tx_vec_t txq[$];
  rx_vec_t rxq[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    if0.send_wr = 0; if0.send_addr = 0; if0.send_data = 0; if0.net_tx_ready = 0;
    if0.net_rx_valid = 0; if0.net_rx_addr = 0; if0.net_rx_data = 0; if0.recv_rd = 0;
    if1.send_wr = 0; if1.send_addr = 0; if1.send_data = 0; if1.net_tx_ready = 0;
    if1.net_rx_valid = 0; if1.net_rx_addr = 0; if1.net_rx_data = 0; if1.recv_rd = 0;
  endtask

  task automatic tx0_step(input logic wr, input logic [7:0] a, input logic [31:0] d, input logic txr);
    @(negedge clk);
    if0.send_wr = wr; if0.send_addr = a; if0.send_data = d; if0.net_tx_ready = txr;
    @(posedge clk); #1;
  endtask

  task automatic rx_step(input int which, input logic v, input logic [7:0] a,
                         input logic [31:0] d, input logic rrd);
    @(negedge clk);
    if (which == 0) begin
      if0.net_rx_valid = v; if0.net_rx_addr = a; if0.net_rx_data = d; if0.recv_rd = rrd;
    end else begin
      if1.net_rx_valid = v; if1.net_rx_addr = a; if1.net_rx_data = d; if1.recv_rd = rrd;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    idle_all();

    // tx vectors: inputs {wr, addr, data, ready}; expected {ack, full, valid, head}
    txq.push_back('{1, 8'h05, 32'hDEADBEEF, 1, 1, 0, 1, 8'h05, 32'hDEADBEEF});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 0, 8'h00, 32'h0});
    txq.push_back('{1, 8'h01, 32'h100,      0, 1, 0, 1, 8'h01, 32'h100});
    txq.push_back('{1, 8'h02, 32'h101,      0, 1, 0, 1, 8'h01, 32'h100});
    txq.push_back('{1, 8'h03, 32'h102,      0, 1, 0, 1, 8'h01, 32'h100});
    txq.push_back('{1, 8'h04, 32'h103,      0, 1, 1, 1, 8'h01, 32'h100});
    txq.push_back('{1, 8'h05, 32'h104,      0, 0, 1, 1, 8'h01, 32'h100});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 1, 8'h02, 32'h101});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 1, 8'h03, 32'h102});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 1, 8'h04, 32'h103});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 0, 8'h00, 32'h0});
    txq.push_back('{1, 8'h09, 32'h900,      0, 1, 0, 1, 8'h09, 32'h900});
    txq.push_back('{1, 8'h0A, 32'hA00,      1, 1, 0, 1, 8'h0A, 32'hA00});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 0, 8'h00, 32'h0});
    txq.push_back('{1, 8'h01, 32'hB0,       0, 1, 0, 1, 8'h01, 32'hB0});
    txq.push_back('{1, 8'h02, 32'hB1,       0, 1, 0, 1, 8'h01, 32'hB0});
    txq.push_back('{1, 8'h03, 32'hB2,       0, 1, 0, 1, 8'h01, 32'hB0});
    txq.push_back('{1, 8'h04, 32'hB3,       0, 1, 1, 1, 8'h01, 32'hB0});
    txq.push_back('{1, 8'h05, 32'hB4,       1, 0, 0, 1, 8'h02, 32'hB1});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 1, 8'h03, 32'hB2});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 1, 8'h04, 32'hB3});
    txq.push_back('{0, 8'h00, 32'h0,        1, 0, 0, 0, 8'h00, 32'h0});

    // rx vectors (backpressure mode): inputs {valid, addr, data, rd};
    // expected {recv_valid, head, rx_count, net_rx_ready}
    rxq.push_back('{1, 8'h20, 32'hC00, 0, 1, 8'h20, 32'hC00, 3'd1, 1});
    rxq.push_back('{1, 8'h21, 32'hC01, 0, 1, 8'h20, 32'hC00, 3'd2, 1});
    rxq.push_back('{1, 8'h22, 32'hC02, 0, 1, 8'h20, 32'hC00, 3'd3, 1});
    rxq.push_back('{1, 8'h23, 32'hC03, 0, 1, 8'h20, 32'hC00, 3'd4, 0});
    rxq.push_back('{1, 8'h24, 32'hC04, 0, 1, 8'h20, 32'hC00, 3'd4, 0});
    rxq.push_back('{1, 8'h24, 32'hC04, 1, 1, 8'h21, 32'hC01, 3'd3, 1});
    rxq.push_back('{1, 8'h24, 32'hC04, 0, 1, 8'h21, 32'hC01, 3'd4, 0});
    rxq.push_back('{0, 8'h00, 32'h0,   1, 1, 8'h22, 32'hC02, 3'd3, 1});
    rxq.push_back('{0, 8'h00, 32'h0,   1, 1, 8'h23, 32'hC03, 3'd2, 1});
    rxq.push_back('{0, 8'h00, 32'h0,   1, 1, 8'h24, 32'hC04, 3'd1, 1});
    rxq.push_back('{0, 8'h00, 32'h0,   1, 0, 8'h00, 32'h0,   3'd0, 1});
    rxq.push_back('{0, 8'h00, 32'h0,   1, 0, 8'h00, 32'h0,   3'd0, 1});

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dut0_outs",
        {if0.send_full, if0.ack, if0.net_tx_valid, if0.recv_valid, if0.net_rx_ready, if0.rx_count, if0.overflow_cnt},
        64'd0);
    chk("rst_dut1_outs",
        {if1.send_full, if1.ack, if1.net_tx_valid, if1.recv_valid, if1.net_rx_ready, if1.rx_count, if1.overflow_cnt},
        64'd0);
    chk("rst_dut0_data", {if0.net_tx_addr, if0.net_tx_data, if0.recv_addr, if0.recv_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst_dut0", if0.net_rx_ready, 1);
    chk("ready_after_rst_dut1", if1.net_rx_ready, 1);

    // ---- tx table ----
    foreach (txq[i]) begin
      tx0_step(txq[i].wr, txq[i].a, txq[i].d, txq[i].txr);
      chk($sformatf("tx_row%0d", i),
          {if0.ack, if0.send_full, if0.net_tx_valid, if0.net_tx_addr, if0.net_tx_data},
          {txq[i].e_ack, txq[i].e_full, txq[i].e_txv, txq[i].e_txa, txq[i].e_txd});
    end
    tx0_step(0, 0, 0, 0);

    // ---- rx table, backpressure mode ----
    foreach (rxq[i]) begin
      rx_step(0, rxq[i].rxv, rxq[i].ra, rxq[i].rd, rxq[i].rrd);
      chk($sformatf("rx_row%0d", i),
          {if0.recv_valid, if0.recv_addr, if0.recv_data, if0.rx_count, if0.net_rx_ready},
          {rxq[i].e_rv, rxq[i].e_ra, rxq[i].e_rd, rxq[i].e_cnt, rxq[i].e_rdy});
    end
    rx_step(0, 0, 0, 0, 0);
    chk("mode0_no_overflow", if0.overflow_cnt, 0);

    // ---- drop mode: fill, drop, same-edge pop, saturate ----
    for (int i = 0; i < 4; i++) rx_step(1, 1, 8'h30 + 8'(i), 32'hD00 + i, 0);
    chk("m1_fill", {if1.rx_count, if1.net_rx_ready, if1.overflow_cnt, if1.recv_addr, if1.recv_data},
        {3'd4, 1'b1, 8'd0, 8'h30, 32'hD00});
    for (int i = 0; i < 3; i++) rx_step(1, 1, 8'h40, 32'hEEEE, 0);
    chk("m1_drop3", {if1.rx_count, if1.net_rx_ready, if1.overflow_cnt, if1.recv_addr, if1.recv_data},
        {3'd4, 1'b1, 8'd3, 8'h30, 32'hD00});
    rx_step(1, 1, 8'h41, 32'hEEEF, 1);
    chk("m1_pop_and_drop", {if1.rx_count, if1.overflow_cnt, if1.recv_addr, if1.recv_data},
        {3'd3, 8'd4, 8'h31, 32'hD01});
    rx_step(1, 1, 8'h42, 32'hD04, 0);
    chk("m1_refill", {if1.rx_count, if1.overflow_cnt}, {3'd4, 8'd4});
    for (int i = 0; i < 300; i++) begin
      rx_step(1, 1, 8'h50, 32'hF00 + i, 0);
      if (i == 249) chk("m1_ovf_254", if1.overflow_cnt, 8'd254);
    end
    rx_step(1, 0, 0, 0, 0);
    chk("m1_ovf_sat", {if1.overflow_cnt, if1.rx_count, if1.recv_addr, if1.recv_data},
        {8'd255, 3'd4, 8'h31, 32'hD01});

    // ---- reset mid-transfer: 3 tx + 2 rx queued ----
    for (int i = 0; i < 3; i++) tx0_step(1, 8'h60 + 8'(i), 32'h600 + i, 0);
    tx0_step(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) rx_step(0, 1, 8'h70 + 8'(i), 32'h700 + i, 0);
    rx_step(0, 0, 0, 0, 0);
    chk("pre_rst_state", {if0.net_tx_valid, if0.recv_valid, if0.rx_count}, {1'b1, 1'b1, 3'd2});
    @(negedge clk);
    if0.send_wr = 1; if0.send_addr = 8'h77; if0.send_data = 32'h777;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dut0",
        {if0.net_tx_valid, if0.recv_valid, if0.rx_count, if0.send_full, if0.ack, if0.net_rx_ready},
        64'd0);
    chk("async_rst_dut1", {if1.recv_valid, if1.rx_count, if1.overflow_cnt, if1.net_rx_ready}, 64'd0);
    @(posedge clk); #1;
    chk("no_ack_on_rst_edge", {if0.ack, if0.net_tx_valid}, 64'd0);
    @(negedge clk);
    idle_all();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {if0.net_rx_ready, if1.net_rx_ready, if0.net_tx_valid}, {1'b1, 1'b1, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
